hand_gesture_fsm: RTL and testbench
===================================

// Module: hand_gesture_fsm
// PURPOSE
//  Downstream of the per-frame colour zone finder. Consumes one blue and one red marker zone per frame.
//  Tracks each marker's column/row across frames; emits swipe gestures (L/R/U/D per colour).
//  Output is a valid/ready stream with a 1-entry output register.
// PARAMETERS
//  NX       8   zone grid columns (zone = row*NX + col)
//  NY       6   zone grid rows
//  ZONES    NX*NY  number of valid zones; zone >= ZONES means "marker absent"
//  MIN_DX   3   |column displacement| needed for a horizontal swipe
//  MIN_DY   2   |row displacement| needed for a vertical swipe
//  WIN      8   frames tracked before re-anchoring (2..255)
//  COOL     4   frames ignored after a gesture (1..255)
// PORTS
//  pclk        in   1  pixel clock
//  rst_n       in   1  asynchronous active-low reset
//  frame_tick  in   1  one-cycle pulse: blue_zone/red_zone hold this frame's result
//  blue_zone   in   7  blue marker zone id
//  red_zone    in   7  red marker zone id
//  gest_ready  in   1  consumer accepts gesture
//  gest_valid  out  1  gesture pending
//  gest_code   out  3  [2]=colour (0 blue, 1 red); [1:0]=00 left, 01 right, 10 up, 11 down
//  blue_active out  1  blue tracker in TRACK
//  red_active  out  1  red tracker in TRACK
// BEHAVIOUR
//  - Reset values: all outputs 0; both trackers IDLE; counters and anchors 0. Reset is async at any time, mid-gesture included.
//  - Zone split: col = zone % NX, row = zone / NX, combinational. Use shift/mask when NX is a power of 2.
//  - Trackers advance only on cycles with frame_tick=1. Zone inputs are ignored otherwise.
//  - Per-colour FSM, two identical instances:
//    IDLE:  tick with valid zone -> latch anchor col/row, fcnt=0 -> TRACK. Invalid zone -> stay.
//    TRACK: tick with invalid zone -> IDLE.
//           Otherwise dx = col-anchor_col and dy = row-anchor_row, both signed, width clog2(max(NX,NY))+1.
//           If |dx|>=MIN_DX: horizontal swipe (dx<0 left, dx>0 right). Horizontal wins when both qualify.
//           Else if |dy|>=MIN_DY: vertical swipe (dy<0 up, dy>0 down). Row 0 is the top of the image.
//           Swipe -> request emit, ccnt=0 -> COOL.
//           No swipe and fcnt==WIN-1 -> re-anchor to current col/row, fcnt=0, stay TRACK.
//           No swipe otherwise -> fcnt++.
//    COOL:  count ticks; after COOL ticks -> IDLE. Zone values are ignored.
//  - Output slot: slot_free = !gest_valid | gest_ready.
//    - Emit request with slot_free: gest_code loads and gest_valid=1 on the next cycle (latency 1 from the tick cycle).
//    - gest_valid&gest_ready with no new request: gest_valid clears next cycle.
//    - gest_code is stable while gest_valid=1 and gest_ready=0.
//  - Simultaneous blue and red requests: blue wins the slot; red is dropped.
//  - Request while the slot is not free: dropped.
//  - A tracker whose request is dropped still enters COOL. There is no retry.
//  - No combinational path from inputs to outputs.
// CONFIGURATION
//  HAND_GESTURE_STATS_EN defined:
//    - Adds output port drop_cnt[15:0], reset 0.
//    - drop_cnt increments once per dropped gesture: +2 if both colours drop in one cycle. Saturates at 16'hFFFF.
//  HAND_GESTURE_STATS_EN undefined: port and counter are absent; behaviour is otherwise identical.
// TESTING
//  1. Blue zones 16,17,18,19 on successive ticks, ready=1 -> code 3'b001 one cycle after 4th tick; blue_active drops.
//  2. Red zones 3,11,19 (row 0->2, col 3) -> code 3'b111 (red down) after 3rd tick.
//  3. Blue 0->3 and red 40->43 on same ticks, ready=1 -> only 3'b001 emitted; drop_cnt=1 with STATS_EN.
//  4. gest_ready=0, blue swipe then red swipe 10 frames later:
//     - gest_code holds the blue code throughout; the red gesture is dropped.
//     - Raise ready -> valid clears next cycle.
//  5. Blue zone 20 for 8 ticks, then 21,22 -> no gesture (re-anchor at tick 8).
//     Blue 48 (absent) mid-TRACK -> IDLE, blue_active=0.
//  6. Assert rst_n=0 during COOL with gest_valid=1 -> valid, code, and active flags 0 immediately.
//     After release, a fresh swipe is detected normally.

Source files
------------

// File: rtl/hand_gesture_fsm.sv
// Swipe-gesture detector: per-colour zone trackers feeding a 1-entry valid/ready output register.
// Optional drop statistics port drop_cnt enabled by defining HAND_GESTURE_STATS_EN.

module hand_gesture_track #(
   parameter int NX     = 8,
   parameter int NY     = 6,
   parameter int MIN_DX = 3,
   parameter int MIN_DY = 2,
   parameter int WIN    = 8,
   parameter int COOL   = 4
) (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic       tick_i,
   input  logic [6:0] zone_i,
   output logic       req_o,
   output logic [1:0] dir_o,
   output logic       active_o
);
   localparam int CW = (NX > 1) ? $clog2(NX) : 1;
   localparam int RW = (NY > 1) ? $clog2(NY) : 1;
   localparam int DW = $clog2((NX > NY) ? NX : NY) + 1;
   localparam logic [6:0]    ZONES_W   = 7'(NX * NY);
   localparam logic [6:0]    NX_W      = 7'(NX);
   localparam logic [DW-1:0] MIN_DX_W  = DW'(MIN_DX);
   localparam logic [DW-1:0] MIN_DY_W  = DW'(MIN_DY);
   localparam logic [7:0]    WIN_LAST  = 8'(WIN - 1);
   localparam logic [7:0]    COOL_LAST = 8'(COOL - 1);

   typedef enum logic [1:0] {S_IDLE, S_TRACK, S_COOL} state_t;

   state_t                state_q;
   logic [CW-1:0]         anc_col_q;
   logic [RW-1:0]         anc_row_q;
   logic [7:0]            fcnt_q;
   logic [7:0]            ccnt_q;

   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic                  zone_valid;
   logic signed [DW-1:0]  dx;
   logic signed [DW-1:0]  dy;
   logic [DW-1:0]         adx;
   logic [DW-1:0]         ady;
   logic                  h_hit;
   logic                  v_hit;

   generate
      if (NX > 1 && (NX & (NX - 1)) == 0) begin : g_pow2
         assign col = zone_i[CW-1:0];
         assign row = RW'(zone_i >> CW);
      end else begin : g_div
         assign col = CW'(zone_i % NX_W);
         assign row = RW'(zone_i / NX_W);
      end
   endgenerate

   assign zone_valid = (zone_i < ZONES_W);
   assign dx  = DW'(col) - DW'(anc_col_q);
   assign dy  = DW'(row) - DW'(anc_row_q);
   assign adx = dx[DW-1] ? DW'(-dx) : DW'(dx);
   assign ady = dy[DW-1] ? DW'(-dy) : DW'(dy);

   // Horizontal displacement takes priority when both axes qualify.
   always_comb begin
      h_hit = (adx >= MIN_DX_W);
      v_hit = (ady >= MIN_DY_W);
      if (h_hit) dir_o = dx[DW-1] ? 2'b00 : 2'b01;
      else       dir_o = dy[DW-1] ? 2'b10 : 2'b11;
      req_o = tick_i && (state_q == S_TRACK) && zone_valid && (h_hit || v_hit);
   end

   assign active_o = (state_q == S_TRACK);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         anc_col_q <= '0;
         anc_row_q <= '0;
         fcnt_q    <= '0;
         ccnt_q    <= '0;
      end else if (tick_i) begin
         case (state_q)
            S_IDLE: begin
               if (zone_valid) begin
                  anc_col_q <= col;
                  anc_row_q <= row;
                  fcnt_q    <= '0;
                  state_q   <= S_TRACK;
               end
            end
            S_TRACK: begin
               if (!zone_valid) begin
                  state_q <= S_IDLE;
               end else if (h_hit || v_hit) begin
                  ccnt_q  <= '0;
                  state_q <= S_COOL;
               end else if (fcnt_q == WIN_LAST) begin
                  anc_col_q <= col;
                  anc_row_q <= row;
                  fcnt_q    <= '0;
               end else begin
                  fcnt_q <= fcnt_q + 8'd1;
               end
            end
            S_COOL: begin
               if (ccnt_q == COOL_LAST) state_q <= S_IDLE;
               else                     ccnt_q  <= ccnt_q + 8'd1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

module hand_gesture_fsm #(
   parameter int NX     = 8,
   parameter int NY     = 6,
   parameter int MIN_DX = 3,
   parameter int MIN_DY = 2,
   parameter int WIN    = 8,
   parameter int COOL   = 4
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic [6:0]  blue_zone,
   input  logic [6:0]  red_zone,
   input  logic        gest_ready,
   output logic        gest_valid,
   output logic [2:0]  gest_code,
   output logic        blue_active,
   output logic        red_active
`ifdef HAND_GESTURE_STATS_EN
   ,
   output logic [15:0] drop_cnt
`endif
);
   logic [6:0] zone [2];
   logic [1:0] req;
   logic [1:0] dir [2];
   logic [1:0] act;

   logic       gest_valid_q, gest_valid_d;
   logic [2:0] gest_code_q, gest_code_d;
   logic       slot_free;

   assign zone[0] = blue_zone;
   assign zone[1] = red_zone;

   // Index 0 is blue, index 1 is red; the colour bit of gest_code equals the index.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_trk
         hand_gesture_track #(
            .NX(NX), .NY(NY), .MIN_DX(MIN_DX), .MIN_DY(MIN_DY), .WIN(WIN), .COOL(COOL)
         ) u_trk (
            .pclk    (pclk),
            .rst_n   (rst_n),
            .tick_i  (frame_tick),
            .zone_i  (zone[gi]),
            .req_o   (req[gi]),
            .dir_o   (dir[gi]),
            .active_o(act[gi])
         );
      end
   endgenerate

   always_comb begin
      slot_free    = !gest_valid_q || gest_ready;
      gest_valid_d = gest_valid_q;
      gest_code_d  = gest_code_q;
      if (slot_free) begin
         if (req[0]) begin
            gest_valid_d = 1'b1;
            gest_code_d  = {1'b0, dir[0]};
         end else if (req[1]) begin
            gest_valid_d = 1'b1;
            gest_code_d  = {1'b1, dir[1]};
         end else if (gest_ready) begin
            gest_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         gest_valid_q <= 1'b0;
         gest_code_q  <= '0;
      end else begin
         gest_valid_q <= gest_valid_d;
         gest_code_q  <= gest_code_d;
      end
   end

   assign gest_valid  = gest_valid_q;
   assign gest_code   = gest_code_q;
   assign blue_active = act[0];
   assign red_active  = act[1];

`ifdef HAND_GESTURE_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        drop_b, drop_r;
   logic [16:0] drop_sum;

   // Red loses the slot to a simultaneous blue request as well as to a busy slot.
   always_comb begin
      drop_b   = req[0] && !slot_free;
      drop_r   = req[1] && (!slot_free || req[0]);
      drop_sum = {1'b0, drop_cnt_q} + 17'(drop_b) + 17'(drop_r);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_hand_gesture_fsm.sv
// Directed bench for hand_gesture_fsm: swipes in all directions, arbitration, backpressure,
// re-anchoring, absent markers and asynchronous reset mid-gesture.

module tb_hand_gesture_fsm;
   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic [6:0]  blue_zone = 7'd0;
   logic [6:0]  red_zone = 7'd0;
   logic        gest_ready = 1'b0;
   logic        gest_valid;
   logic [2:0]  gest_code;
   logic        blue_active;
   logic        red_active;
`ifdef HAND_GESTURE_STATS_EN
   logic [15:0] drop_cnt;
`endif

   int errors = 0;
   int checks = 0;
   localparam logic [6:0] ABS = 7'd48;

   always #5 pclk = ~pclk;

   hand_gesture_fsm dut (
      .pclk       (pclk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .blue_zone  (blue_zone),
      .red_zone   (red_zone),
      .gest_ready (gest_ready),
      .gest_valid (gest_valid),
      .gest_code  (gest_code),
      .blue_active(blue_active),
      .red_active (red_active)
`ifdef HAND_GESTURE_STATS_EN
      ,
      .drop_cnt   (drop_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One frame tick; returns 1 time unit after the sampling edge.
   task automatic tick(input logic [6:0] b, input logic [6:0] r);
      @(negedge pclk);
      frame_tick = 1'b1;
      blue_zone  = b;
      red_zone   = r;
      @(posedge pclk);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic flush();
      repeat (5) tick(ABS, ABS);
   endtask

   initial begin
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_valid", gest_valid, 0);
      chk("rst_code", gest_code, 0);
      chk("rst_blue_act", blue_active, 0);
      chk("rst_red_act", red_active, 0);
`ifdef HAND_GESTURE_STATS_EN
      chk("rst_drop", drop_cnt, 0);
`endif
      @(negedge pclk);
      rst_n = 1'b1;
      gest_ready = 1'b1;

      // blue right
      tick(7'd16, ABS);
      chk("t1_blue_act", blue_active, 1);
      tick(7'd17, ABS);
      tick(7'd18, ABS);
      chk("t1_no_early", gest_valid, 0);
      tick(7'd19, ABS);
      chk("t1_valid", gest_valid, 1);
      chk("t1_code", gest_code, 3'b001);
      chk("t1_blue_idle", blue_active, 0);
      cyc(1);
      chk("t1_clear", gest_valid, 0);
      flush();

      // red down
      tick(ABS, 7'd3);
      chk("t2_red_act", red_active, 1);
      tick(ABS, 7'd11);
      chk("t2_no_early", gest_valid, 0);
      tick(ABS, 7'd19);
      chk("t2_valid", gest_valid, 1);
      chk("t2_code", gest_code, 3'b111);
      chk("t2_red_idle", red_active, 0);
      flush();

      // blue left, red up
      tick(7'd19, ABS);
      tick(7'd18, ABS);
      tick(7'd17, ABS);
      tick(7'd16, ABS);
      chk("left_valid", gest_valid, 1);
      chk("left_code", gest_code, 3'b000);
      flush();
      tick(ABS, 7'd19);
      tick(ABS, 7'd11);
      tick(ABS, 7'd3);
      chk("up_valid", gest_valid, 1);
      chk("up_code", gest_code, 3'b110);
      flush();

      // simultaneous blue/red swipes
      for (int i = 0; i < 4; i++) tick(7'(i), 7'(40 + i));
      chk("t3_valid", gest_valid, 1);
      chk("t3_code", gest_code, 3'b001);
`ifdef HAND_GESTURE_STATS_EN
      chk("t3_drop", drop_cnt, 1);
`endif
      cyc(1);
      chk("t3_clear", gest_valid, 0);
      flush();

      // backpressure
      gest_ready = 1'b0;
      for (int i = 0; i < 4; i++) tick(7'(16 + i), ABS);
      chk("t4_valid", gest_valid, 1);
      chk("t4_code", gest_code, 3'b001);
      repeat (6) tick(ABS, ABS);
      chk("t4_hold_code", gest_code, 3'b001);
      tick(ABS, 7'd3);
      tick(ABS, 7'd11);
      tick(ABS, 7'd19);
      chk("t4_still_valid", gest_valid, 1);
      chk("t4_still_code", gest_code, 3'b001);
      chk("t4_red_cool", red_active, 0);
`ifdef HAND_GESTURE_STATS_EN
      chk("t4_drop", drop_cnt, 2);
`endif
      @(negedge pclk);
      gest_ready = 1'b1;
      cyc(1);
      chk("t4_clear", gest_valid, 0);
      flush();

      // window expiry re-anchors, so 20 -> 23 never reaches MIN_DX
      repeat (8) tick(7'd20, ABS);
      chk("t5_blue_act", blue_active, 1);
      tick(7'd21, ABS);
      chk("t5_no_g21", gest_valid, 0);
      tick(7'd22, ABS);
      chk("t5_no_g22", gest_valid, 0);
      tick(7'd23, ABS);
      chk("t5_no_g23", gest_valid, 0);
      chk("t5_still_act", blue_active, 1);
      tick(ABS, ABS);
      chk("t5_absent_idle", blue_active, 0);
      flush();

      // async reset while gesture pending and blue cooling
      gest_ready = 1'b0;
      for (int i = 0; i < 4; i++) tick(7'(16 + i), 7'd3);
      chk("t6_valid", gest_valid, 1);
      chk("t6_red_act", red_active, 1);
      @(posedge pclk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", gest_valid, 0);
      chk("t6_rst_code", gest_code, 0);
      chk("t6_rst_blue", blue_active, 0);
      chk("t6_rst_red", red_active, 0);
      @(negedge pclk);
      rst_n = 1'b1;
      gest_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick(7'(16 + i), ABS);
      chk("t6_fresh_valid", gest_valid, 1);
      chk("t6_fresh_code", gest_code, 3'b001);
`ifdef HAND_GESTURE_STATS_EN
      chk("t6_drop", drop_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
